// File: rtl/adam_pause_sequencer_if.sv
// rtl/adam_pause_sequencer_if.sv - pause handshake bundle between upstream, sequencer and targets
//
// Signals:
//   pause_req  upstream pause request
//   pause_ack  upstream pause acknowledge
//   ch_req     per-channel pause request to the downstream targets
//   ch_ack     per-channel pause acknowledge from the downstream targets
// Modports:
//   master  sequencer view (drives pause_ack and ch_req)
//   slave   environment view (drives pause_req and ch_ack)
interface adam_pause_sequencer_if #(
    parameter int NO_CHANNELS = 4
);
    logic                   pause_req;
    logic                   pause_ack;
    logic [NO_CHANNELS-1:0] ch_req;
    logic [NO_CHANNELS-1:0] ch_ack;

    modport master (
        input  pause_req,
        input  ch_ack,
        output pause_ack,
        output ch_req
    );

    modport slave (
        output pause_req,
        output ch_ack,
        input  pause_ack,
        input  ch_req
    );
endinterface

// File: rtl/adam_pause_sequencer.sv
// rtl/adam_pause_sequencer.sv - orders pause/resume of N targets behind one pause handshake
//
// Pauses enabled channels in ascending index order and resumes them in
// descending order. A change of pause_req mid-sequence reverses direction
// from the current channel.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       pause handshake bundle (master modport)
//   ch_en     channel enable mask, latched at sequence start
//   busy      high while PAUSING or RESUMING
//   err       sticky watchdog error
//   err_ch    index of the first channel that timed out
//   err_clr   clears err and err_ch
//
// Build option: define ADAM_PAUSE_SEQ_WATCHDOG_EN to build the per-step
// watchdog; otherwise steps wait indefinitely and err/err_ch are tied to 0.
module adam_pause_sequencer #(
    parameter int NO_CHANNELS    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_WIDTH      = $clog2(NO_CHANNELS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    adam_pause_sequencer_if.master    bus,
    input  logic [NO_CHANNELS-1:0]    ch_en,
    output logic                      busy,
    output logic                      err,
    output logic [IDX_WIDTH-1:0]      err_ch,
    input  logic                      err_clr
);
    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        PAUSING  = 2'd1,
        PAUSED   = 2'd2,
        RESUMING = 2'd3
    } state_t;

    localparam logic [NO_CHANNELS-1:0] ONE      = NO_CHANNELS'(1);
    localparam logic [IDX_WIDTH-1:0]   LAST     = IDX_WIDTH'(NO_CHANNELS - 1);
    localparam logic [NO_CHANNELS-1:0] LAST_BIT = ONE << (NO_CHANNELS - 1);

    state_t                 state;
    logic [IDX_WIDTH-1:0]   idx;
    logic [NO_CHANNELS-1:0] en_q;
    logic [NO_CHANNELS-1:0] ch_req;
    logic                   pause_ack;

    logic [NO_CHANNELS-1:0] cur_bit;
    logic                   cur_en;
    logic                   cur_ack;
    logic                   active;
    logic                   reverse;
    logic                   step_nat;
    logic                   step_done;
    logic                   wd_fire;

    assign bus.ch_req    = ch_req;
    assign bus.pause_ack = pause_ack;

    // One-hot of the current step avoids index-width mismatches.
    assign cur_bit  = ONE << idx;
    assign cur_en   = |(en_q & cur_bit);
    assign cur_ack  = |(bus.ch_ack & cur_bit);
    assign active   = (state == PAUSING) || (state == RESUMING);
    assign reverse  = ((state == PAUSING) && !bus.pause_req) ||
                      ((state == RESUMING) && bus.pause_req);
    // A step completes when the target's ack matches the requested level;
    // disabled steps complete in their single cycle.
    assign step_nat  = !cur_en || ((state == PAUSING) ? cur_ack : !cur_ack);
    // Reversal wins over completion so the current channel is re-stepped
    // in the new direction rather than skipped.
    assign step_done = active && !reverse && (step_nat || wd_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUNNING;
            idx       <= '0;
            en_q      <= '0;
            ch_req    <= '0;
            pause_ack <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                RUNNING: begin
                    if (bus.pause_req) begin
                        state  <= PAUSING;
                        busy   <= 1'b1;
                        en_q   <= ch_en;
                        idx    <= '0;
                        // Raise channel 0 on entry so an enabled step costs
                        // only the target's latency.
                        ch_req <= ch_en & ONE;
                    end
                end
                PAUSED: begin
                    if (!bus.pause_req) begin
                        state  <= RESUMING;
                        busy   <= 1'b1;
                        idx    <= LAST;
                        ch_req <= ch_req & ~LAST_BIT;
                    end
                end
                PAUSING: begin
                    if (reverse) begin
                        state  <= RESUMING;
                        ch_req <= ch_req & ~cur_bit;
                    end else if (step_done) begin
                        if (idx == LAST) begin
                            state     <= PAUSED;
                            busy      <= 1'b0;
                            pause_ack <= 1'b1;
                        end else begin
                            idx    <= idx + 1'b1;
                            ch_req <= ch_req | (en_q & (cur_bit << 1));
                        end
                    end
                end
                RESUMING: begin
                    if (reverse) begin
                        state  <= PAUSING;
                        ch_req <= ch_req | (en_q & cur_bit);
                    end else if (step_done) begin
                        if (idx == '0) begin
                            state     <= RUNNING;
                            busy      <= 1'b0;
                            pause_ack <= 1'b0;
                        end else begin
                            idx    <= idx - 1'b1;
                            ch_req <= ch_req & ~(cur_bit >> 1);
                        end
                    end
                end
                default: state <= RUNNING;
            endcase
        end
    end

`ifdef ADAM_PAUSE_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]      wdog;
    logic                 err_q;
    logic [IDX_WIDTH-1:0] err_ch_q;
    logic                 waiting;

    assign waiting = active && !reverse && !step_nat;
    // Fires on the last allowed waiting cycle; the step is then forced
    // complete on the same edge with the request level left as sequenced.
    assign wd_fire = waiting && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (waiting && !wd_fire) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            err_ch_q <= '0;
        end else if (wd_fire && (!err_q || err_clr)) begin
            err_q    <= 1'b1;
            err_ch_q <= idx;
        end else if (err_clr) begin
            err_q    <= 1'b0;
            err_ch_q <= '0;
        end
    end

    assign err    = err_q;
    assign err_ch = err_ch_q;
`else
    wire [31:0] unused_timeout = 32'(TIMEOUT_CYCLES);
    wire        unused_clr     = err_clr;

    assign wd_fire = 1'b0;
    assign err     = 1'b0;
    assign err_ch  = '0;
`endif
endmodule

// File: tb/tb_adam_pause_sequencer.sv
// tb/tb_adam_pause_sequencer.sv - self-checking bench for adam_pause_sequencer
module tb_adam_pause_sequencer;
    localparam int N  = 4;
    localparam int IW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ch_en;
    logic [N-1:0]  dead;
    logic          busy;
    logic          err;
    logic [IW-1:0] err_ch;
    logic          err_clr;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    adam_pause_sequencer_if #(.NO_CHANNELS(N)) bus ();

    adam_pause_sequencer #(
        .NO_CHANNELS   (N),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .ch_en  (ch_en),
        .busy   (busy),
        .err    (err),
        .err_ch (err_ch),
        .err_clr(err_clr)
    );

    // Targets acknowledge one cycle after request; dead channels never ack.
    always_ff @(posedge clk) begin
        if (rst) bus.ch_ack <= '0;
        else     bus.ch_ack <= bus.ch_req & ~dead;
    end

    typedef struct {
        logic         preq;
        logic [N-1:0] en;
        logic [N-1:0] req;
        logic         ack;
        logic         bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic preq, input logic [N-1:0] en,
                       input logic [N-1:0] req, input logic ack, input logic bsy);
        vec_t v;
        v.preq = preq; v.en = en; v.req = req; v.ack = ack; v.bsy = bsy;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    initial begin
        logic [N-1:0] prev;
        logic [11:0]  seq;
        int           nfall;
        int           n;
        logic         saw_ack;

        rst = 1'b1; ch_en = '0; dead = '0; err_clr = 1'b0; bus.pause_req = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        chk("reset ch_req", 32'(bus.ch_req), 0);
        chk("reset pause_ack", 32'(bus.pause_ack), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset err", 32'(err), 0);
        chk("reset err_ch", 32'(err_ch), 0);

        // Full pause/resume, all channels enabled.
        add(1, 4'b1111, 4'b0001, 0, 1); add(1, 4'b1111, 4'b0001, 0, 1);
        add(1, 4'b1111, 4'b0011, 0, 1); add(1, 4'b1111, 4'b0011, 0, 1);
        add(1, 4'b1111, 4'b0111, 0, 1); add(1, 4'b1111, 4'b0111, 0, 1);
        add(1, 4'b1111, 4'b1111, 0, 1); add(1, 4'b1111, 4'b1111, 0, 1);
        add(1, 4'b1111, 4'b1111, 1, 0);
        add(0, 4'b1111, 4'b0111, 1, 1); add(0, 4'b1111, 4'b0111, 1, 1);
        add(0, 4'b1111, 4'b0011, 1, 1); add(0, 4'b1111, 4'b0011, 1, 1);
        add(0, 4'b1111, 4'b0001, 1, 1); add(0, 4'b1111, 4'b0001, 1, 1);
        add(0, 4'b1111, 4'b0000, 1, 1); add(0, 4'b1111, 4'b0000, 1, 1);
        add(0, 4'b1111, 4'b0000, 0, 0);
        // Sparse mask 0101, then ch_en toggled while paused, then resume.
        add(1, 4'b0101, 4'b0001, 0, 1); add(1, 4'b0101, 4'b0001, 0, 1);
        add(1, 4'b0101, 4'b0001, 0, 1); add(1, 4'b0101, 4'b0101, 0, 1);
        add(1, 4'b0101, 4'b0101, 0, 1); add(1, 4'b0101, 4'b0101, 0, 1);
        add(1, 4'b0101, 4'b0101, 1, 0);
        add(1, 4'b1010, 4'b0101, 1, 0); add(1, 4'b1111, 4'b0101, 1, 0);
        add(0, 4'b1111, 4'b0101, 1, 1); add(0, 4'b1111, 4'b0001, 1, 1);
        add(0, 4'b1111, 4'b0001, 1, 1); add(0, 4'b1111, 4'b0001, 1, 1);
        add(0, 4'b1111, 4'b0000, 1, 1); add(0, 4'b1111, 4'b0000, 1, 1);
        add(0, 4'b1111, 4'b0000, 0, 0);

        foreach (tbl[i]) begin
            bus.pause_req = tbl[i].preq;
            ch_en         = tbl[i].en;
            tick();
            chk($sformatf("vec%0d ch_req", i), 32'(bus.ch_req), 32'(tbl[i].req));
            chk($sformatf("vec%0d pause_ack", i), 32'(bus.pause_ack), 32'(tbl[i].ack));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
        end

        // Reversal while channel 2 is waiting.
        ch_en = 4'b1111; bus.pause_req = 1'b1;
        n = 0;
        while (bus.ch_req !== 4'b0111 && n < 20) begin tick(); n++; end
        chk("rev reach 0111", 32'(bus.ch_req), 32'h7);
        bus.pause_req = 1'b0;
        prev = bus.ch_req; seq = '0; nfall = 0; saw_ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.pause_ack) saw_ack = 1'b1;
            for (int b = N - 1; b >= 0; b--) begin
                if (prev[b] && !bus.ch_req[b]) begin
                    seq = {seq[7:0], 4'(b)};
                    nfall++;
                end
            end
            prev = bus.ch_req;
        end
        chk("rev fall count", 32'(nfall), 3);
        chk("rev fall order", 32'(seq), 32'h210);
        chk("rev no pause_ack", 32'(saw_ack), 0);
        chk("rev busy end", 32'(busy), 0);
        chk("rev ch_req end", 32'(bus.ch_req), 0);

        // Reset in the middle of pausing, at channel 2.
        bus.pause_req = 1'b1;
        n = 0;
        while (bus.ch_req !== 4'b0111 && n < 20) begin tick(); n++; end
        chk("rst reach 0111", 32'(bus.ch_req), 32'h7);
        rst = 1'b1; bus.pause_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst ch_req", 32'(bus.ch_req), 0);
        chk("rst pause_ack", 32'(bus.pause_ack), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst state", 32'(dut.state), 0);
        tick();

`ifdef ADAM_PAUSE_SEQ_WATCHDOG_EN
        // Channel 1 never acks: 16 waiting cycles, then forced onward.
        dead = 4'b0010; bus.pause_req = 1'b1;
        n = 0;
        while (!bus.pause_ack && n < 100) begin tick(); n++; end
        chk("wd cycles to pause_ack", 32'(n), 23);
        chk("wd err", 32'(err), 1);
        chk("wd err_ch", 32'(err_ch), 1);
        chk("wd ch_req", 32'(bus.ch_req), 32'hF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd err cleared", 32'(err), 0);
        chk("wd err_ch cleared", 32'(err_ch), 0);
        bus.pause_req = 1'b0;
        n = 0;
        while (bus.pause_ack && n < 100) begin tick(); n++; end
        chk("wd resume pause_ack", 32'(bus.pause_ack), 0);
        chk("wd resume err", 32'(err), 0);
`else
        // Channel 0 never acks: the sequence waits indefinitely.
        dead = 4'b0001; bus.pause_req = 1'b1;
        tick();
        saw_ack = 1'b1;
        n = 0;
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (!busy) saw_ack = 1'b0;
            if (err) n++;
        end
        chk("stall busy held", 32'(saw_ack), 1);
        chk("stall err low", 32'(n), 0);
        chk("stall ch_req", 32'(bus.ch_req), 32'h1);
        chk("stall pause_ack", 32'(bus.pause_ack), 0);
        rst = 1'b1; bus.pause_req = 1'b0; dead = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("stall recover busy", 32'(busy), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
